// File: rtl/gpp_field_collector_pkg.sv
// Shared definitions for the gpp field collector: default field widths, FSM state type
// and the record error rule.
package gpp_field_collector_pkg;

    localparam int unsigned GPP_F0_W = 16;
    localparam int unsigned GPP_F1_W = 16;
    localparam int unsigned GPP_F2_W = 16;
    localparam int unsigned GPP_F3_W = 16;
    localparam int unsigned GPP_F4_W = 16;

    typedef enum logic {
        StIdle,
        StCollect
    } coll_state_e;

    // A record is bad if any field repeated or a required field never arrived.
    function automatic logic rec_err_calc(input logic [4:0] mask,
                                          input logic [4:0] req,
                                          input logic       dup);
        return dup | ((mask & req) != req);
    endfunction

endpackage

// File: rtl/gpp_rec_fifo.sv
// Synchronous record FIFO; pointers carry one extra bit so full and empty are distinguishable.
module gpp_rec_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    count_o
);

    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count_o = wptr_q - rptr_q;
        empty_o = (count_o == '0);
        full_o  = (count_o == PW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push = push_i & (~full_o | do_pop);
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        rdata_o = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/gpp_field_collector.sv
// Collects per-field pulses from gpp into one record per packet and queues the records
// behind a valid/ready interface, counting records lost to a full queue.
module gpp_field_collector
    import gpp_field_collector_pkg::*;
#(
    parameter int unsigned F0_W     = GPP_F0_W,
    parameter int unsigned F1_W     = GPP_F1_W,
    parameter int unsigned F2_W     = GPP_F2_W,
    parameter int unsigned F3_W     = GPP_F3_W,
    parameter int unsigned F4_W     = GPP_F4_W,
    parameter logic [4:0]  REQ_MASK = 5'b11111,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [F0_W-1:0]  f0,
    input  logic [F1_W-1:0]  f1,
    input  logic [F2_W-1:0]  f2,
    input  logic [F3_W-1:0]  f3,
    input  logic [F4_W-1:0]  f4,
    input  logic             f0_v,
    input  logic             f1_v,
    input  logic             f2_v,
    input  logic             f3_v,
    input  logic             f4_v,
    input  logic             pkt_end,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [F0_W-1:0]  rec_f0,
    output logic [F1_W-1:0]  rec_f1,
    output logic [F2_W-1:0]  rec_f2,
    output logic [F3_W-1:0]  rec_f3,
    output logic [F4_W-1:0]  rec_f4,
    output logic [4:0]       rec_mask,
    output logic             rec_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned REC_W = F0_W + F1_W + F2_W + F3_W + F4_W + 5 + 1;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    coll_state_e      state_q, state_d;
    logic [4:0]       mask_q, mask_d;
    logic             dup_q, dup_d;
    logic [F0_W-1:0]  w_f0_q, w_f0_d;
    logic [F1_W-1:0]  w_f1_q, w_f1_d;
    logic [F2_W-1:0]  w_f2_q, w_f2_d;
    logic [F3_W-1:0]  w_f3_q, w_f3_d;
    logic [F4_W-1:0]  w_f4_q, w_f4_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [4:0]       fld_v, cap;
    logic [4:0]       new_mask;
    logic             new_dup;
    logic [F0_W-1:0]  new_f0;
    logic [F1_W-1:0]  new_f1;
    logic [F2_W-1:0]  new_f2;
    logic [F3_W-1:0]  new_f3;
    logic [F4_W-1:0]  new_f4;
    logic             close, pop, drop;
    logic [REC_W-1:0] rec_in, rec_head, rec_out;
    logic             fifo_full, fifo_empty;
    logic [PW-1:0]    fifo_count;

    always_comb begin
        fld_v    = {f4_v, f3_v, f2_v, f1_v, f0_v};
        cap      = fld_v & ~mask_q;
        new_mask = mask_q | fld_v;
        new_dup  = dup_q | (|(fld_v & mask_q));
        new_f0   = cap[0] ? f0 : w_f0_q;
        new_f1   = cap[1] ? f1 : w_f1_q;
        new_f2   = cap[2] ? f2 : w_f2_q;
        new_f3   = cap[3] ? f3 : w_f3_q;
        new_f4   = cap[4] ? f4 : w_f4_q;
        rec_in   = {rec_err_calc(new_mask, REQ_MASK, new_dup), new_mask,
                    new_f4, new_f3, new_f2, new_f1, new_f0};

        state_d = state_q;
        close   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A bare pkt_end with nothing collected produces no record.
                close = pkt_end & (|fld_v);
                if (|fld_v && !pkt_end) state_d = StCollect;
            end
            StCollect: begin
                close = pkt_end;
                if (pkt_end) state_d = StIdle;
            end
        endcase

        mask_d = close ? '0 : new_mask;
        dup_d  = close ? 1'b0 : new_dup;
        w_f0_d = close ? '0 : new_f0;
        w_f1_d = close ? '0 : new_f1;
        w_f2_d = close ? '0 : new_f2;
        w_f3_d = close ? '0 : new_f3;
        w_f4_d = close ? '0 : new_f4;

        pop        = rec_valid & rec_ready;
        drop       = close & fifo_full & ~pop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            dup_q      <= 1'b0;
            w_f0_q     <= '0;
            w_f1_q     <= '0;
            w_f2_q     <= '0;
            w_f3_q     <= '0;
            w_f4_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            dup_q      <= dup_d;
            w_f0_q     <= w_f0_d;
            w_f1_q     <= w_f1_d;
            w_f2_q     <= w_f2_d;
            w_f3_q     <= w_f3_d;
            w_f4_q     <= w_f4_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    gpp_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (close),
        .pop_i   (pop),
        .wdata_i (rec_in),
        .rdata_o (rec_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assert property (@(posedge clk) disable iff (reset) fifo_count <= PW'(DEPTH));

    // Head is forced to zero while empty so stale storage never shows on the outputs.
    assign rec_valid = ~fifo_empty;
    assign rec_out   = rec_valid ? rec_head : '0;
    assign {rec_err, rec_mask, rec_f4, rec_f3, rec_f2, rec_f1, rec_f0} = rec_out;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gpp_field_collector.sv
// Randomised and directed checks of gpp_field_collector against a queue-based packet model.
module tb_gpp_field_collector;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int          DROP_MAX = 15;
    localparam logic [4:0]  REQ      = 5'b11111;

    typedef struct packed {
        logic             err;
        logic [4:0]       mask;
        logic [4:0][15:0] f;
    } rec_t;

    logic             clk;
    logic             rst;
    logic [4:0]       fv;
    logic [15:0]      fd [5];
    logic             pe;
    logic             rdy;
    logic             rec_valid;
    logic [15:0]      rf [5];
    logic [4:0]       rec_mask;
    logic             rec_err;
    logic [CNT_W-1:0] drop_cnt;

    rec_t             q [$];
    logic [4:0][15:0] wf;
    logic [4:0]       wmask;
    logic             wdup;
    int               drops;
    int               n_checks;
    int               n_bad;

    gpp_field_collector #(
        .F0_W     (16),
        .F1_W     (16),
        .F2_W     (16),
        .F3_W     (16),
        .F4_W     (16),
        .REQ_MASK (REQ),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .f0        (fd[0]),
        .f1        (fd[1]),
        .f2        (fd[2]),
        .f3        (fd[3]),
        .f4        (fd[4]),
        .f0_v      (fv[0]),
        .f1_v      (fv[1]),
        .f2_v      (fv[2]),
        .f3_v      (fv[3]),
        .f4_v      (fv[4]),
        .pkt_end   (pe),
        .rec_valid (rec_valid),
        .rec_ready (rdy),
        .rec_f0    (rf[0]),
        .rec_f1    (rf[1]),
        .rec_f2    (rf[2]),
        .rec_f3    (rf[3]),
        .rec_f4    (rf[4]),
        .rec_mask  (rec_mask),
        .rec_err   (rec_err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packet-level model: fold this cycle's pulses into the open packet, then at packet end
    // emit a record into a bounded queue after the consumer's pop.
    task automatic model_update();
        rec_t r;
        bit   pop;
        if (rst) begin
            q.delete();
            wf    = '0;
            wmask = '0;
            wdup  = 1'b0;
            drops = 0;
            return;
        end
        pop = (q.size() > 0) && rdy;
        for (int n = 0; n < 5; n++) begin
            if (fv[n]) begin
                if (wmask[n]) wdup = 1'b1;
                else begin
                    wf[n]    = fd[n];
                    wmask[n] = 1'b1;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (pe && wmask != '0) begin
            r.f    = wf;
            r.mask = wmask;
            r.err  = wdup || ((wmask & REQ) != REQ);
            if (q.size() < DEPTH) q.push_back(r);
            else if (drops < DROP_MAX) drops++;
            wf    = '0;
            wmask = '0;
            wdup  = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("rec_valid", 32'(rec_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            for (int n = 0; n < 5; n++)
                check_eq($sformatf("rec_f%0d", n), 32'(rf[n]), 32'(q[0].f[n]));
            check_eq("rec_mask", 32'(rec_mask), 32'(q[0].mask));
            check_eq("rec_err", 32'(rec_err), 32'(q[0].err));
        end
        check_eq("drop_cnt", 32'(drop_cnt), 32'(drops));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle();
        fv  = '0;
        pe  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic full_pkt(input logic [15:0] tag0);
        fv    = 5'h1F;
        fd[0] = tag0;
        for (int n = 1; n < 5; n++) fd[n] = 16'($urandom);
        pe = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rdy      = 1'b0;
        for (int n = 0; n < 5; n++) fd[n] = '0;
        do_reset();
        check_eq("reset_valid", 32'(rec_valid), 32'd0);
        check_eq("reset_mask", 32'(rec_mask), 32'd0);
        check_eq("reset_f0", 32'(rf[0]), 32'd0);
        check_eq("reset_drop", 32'(drop_cnt), 32'd0);

        // Single packet over two cycles.
        fv = 5'b00011; fd[0] = 16'h1234; fd[1] = 16'hABCD;
        tick();
        check_eq("t1_early_valid", 32'(rec_valid), 32'd0);
        fv = 5'b11100; fd[2] = 16'h0002; fd[3] = 16'h0003; fd[4] = 16'h0004; pe = 1'b1;
        tick();
        idle();
        check_eq("t1_valid", 32'(rec_valid), 32'd1);
        check_eq("t1_mask", 32'(rec_mask), 32'h1F);
        check_eq("t1_err", 32'(rec_err), 32'd0);
        check_eq("t1_f0", 32'(rf[0]), 32'h1234);
        check_eq("t1_f1", 32'(rf[1]), 32'hABCD);
        rdy = 1'b1;
        tick();

        // Missing field 4.
        fv = 5'b01111; fd[4] = 16'hFFFF;
        tick();
        idle(); pe = 1'b1;
        tick();
        idle();
        check_eq("t2_mask", 32'(rec_mask), 32'h0F);
        check_eq("t2_err", 32'(rec_err), 32'd1);
        check_eq("t2_f4", 32'(rf[4]), 32'd0);
        tick();

        // Duplicate field 2 keeps the first value.
        fv = 5'b00100; fd[2] = 16'd5;
        tick();
        fd[2] = 16'd9;
        tick();
        idle(); pe = 1'b1;
        tick();
        idle();
        check_eq("t3_f2", 32'(rf[2]), 32'd5);
        check_eq("t3_err", 32'(rec_err), 32'd1);
        tick();

        // Backpressure: third packet dropped, then drain in order.
        do_reset();
        rdy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            full_pkt(16'(k));
            tick();
        end
        check_eq("t4_drop", 32'(drop_cnt), 32'd1);
        check_eq("t4_head1", 32'(rf[0]), 32'd1);
        rdy = 1'b1;
        tick();
        check_eq("t4_head2", 32'(rf[0]), 32'd2);
        tick();
        check_eq("t4_empty", 32'(rec_valid), 32'd0);

        // Full FIFO with a pop in the same cycle as pkt_end.
        do_reset();
        rdy = 1'b0;
        full_pkt(16'd1);
        full_pkt(16'd2);
        rdy = 1'b1;
        full_pkt(16'd3);
        check_eq("t5_drop", 32'(drop_cnt), 32'd0);
        check_eq("t5_head", 32'(rf[0]), 32'd2);
        tick();
        check_eq("t5_next", 32'(rf[0]), 32'd3);
        tick();

        // Bare pkt_end, and reset in the middle of a packet.
        do_reset();
        pe = 1'b1;
        tick();
        idle();
        tick();
        check_eq("t6_bare_end", 32'(rec_valid), 32'd0);
        fv = 5'b00001; fd[0] = 16'h0077;
        tick();
        idle(); rst = 1'b1;
        tick();
        idle(); pe = 1'b1;
        tick();
        idle();
        tick();
        check_eq("t6_valid", 32'(rec_valid), 32'd0);
        check_eq("t6_mask", 32'(rec_mask), 32'd0);
        check_eq("t6_f0", 32'(rf[0]), 32'd0);
        check_eq("t6_err", 32'(rec_err), 32'd0);
        check_eq("t6_drop", 32'(drop_cnt), 32'd0);

        // Random traffic; the first phase starves the consumer to reach counter saturation.
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 5; n++) begin
                fv[n] = ($urandom_range(0, 3) == 0);
                fd[n] = 16'($urandom);
            end
            pe  = ($urandom_range(0, 4) == 0);
            rdy = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            rst = (c > 1500) && ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
